// File: rtl/ibex_counter_pkg.sv
// ibex_counter_pkg
//  Shared types and constants for the counter CSR access port.
//  - cnt_port_state_e : request/response FSM states
//  - cnt_req_t        : captured CSR request (we, hi, idx, wdata)
//  - MaxCounters      : upper bound on attached counters (idx fits MaxIdxW bits)
package ibex_counter_pkg;

  localparam int unsigned MaxCounters = 32;
  localparam int unsigned MaxIdxW     = $clog2(MaxCounters);

  typedef enum logic {
    CntIdle,
    CntResp
  } cnt_port_state_e;

  typedef struct packed {
    logic               we;
    logic               hi;
    logic [MaxIdxW-1:0] idx;
    logic [31:0]        wdata;
  } cnt_req_t;

endpackage

// File: rtl/ibex_counter_snapshot.sv
// ibex_counter_snapshot
//  Holds the upper half of a counter sampled by a low-half read so that a
//  following high-half read of the same counter returns a coherent 64-bit value.
//  Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   accept_i        a request is accepted this cycle
//   we_i, hi_i      request is a write / targets the upper half
//   in_range_i      request index addresses an existing counter
//   idx_i           request index
//   live_hi_i       upper half of the addressed counter this cycle
//   hit_o           snapshot valid and tagged with idx_i
//   snap_o          stored upper half
module ibex_counter_snapshot
  import ibex_counter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               accept_i,
  input  logic               we_i,
  input  logic               hi_i,
  input  logic               in_range_i,
  input  logic [MaxIdxW-1:0] idx_i,
  input  logic [31:0]        live_hi_i,
  output logic               hit_o,
  output logic [31:0]        snap_o
);

  logic               valid_q;
  logic [MaxIdxW-1:0] tag_q;
  logic [31:0]        data_q;

  assign hit_o  = valid_q && (tag_q == idx_i);
  assign snap_o = data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (accept_i) begin
      if (we_i) begin
        // A write to the tagged counter makes the stored half stale.
        if (hit_o) valid_q <= 1'b0;
      end else if (!hi_i) begin
        // Every low read re-arms; an out-of-range one leaves it empty.
        valid_q <= in_range_i;
        tag_q   <= idx_i;
        data_q  <= live_hi_i;
      end else if (hit_o) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ibex_counter_csr_port.sv
// ibex_counter_csr_port
//  CSR-side access engine for a bank of 64-bit counters. Accepts one 32-bit
//  lo/hi read or write at a time, returns a registered response, pulses the
//  per-counter write strobes one cycle after accept, and gates raw events into
//  increment enables under an inhibit mask.
//  Optional: define IBEX_COUNTER_SNAPSHOT_EN to make lo-then-hi reads of one
//  counter coherent through ibex_counter_snapshot.
//  Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i/req_ready_o        request handshake (one outstanding request)
//   req_we_i, req_hi_i       write / upper-half select
//   req_idx_i, req_wdata_i   counter index, write data
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o   read data, index-out-of-range flag
//   event_i, inhibit_i       raw events, per-counter inhibit
//   counter_val_i            current counter values
//   counter_inc_o            increment enables (combinational)
//   counter_we_o/counterh_we_o  lo/hi write strobes
//   counter_wdata_o          shared write data
module ibex_counter_csr_port
  import ibex_counter_pkg::*;
#(
  parameter  int unsigned NumCounters = 3,
  localparam int unsigned IdxW        = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic                        req_hi_i,
  input  logic [IdxW-1:0]             req_idx_i,
  input  logic [31:0]                 req_wdata_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [31:0]                 rsp_rdata_o,
  output logic                        rsp_err_o,
  input  logic [NumCounters-1:0]      event_i,
  input  logic [NumCounters-1:0]      inhibit_i,
  input  logic [NumCounters-1:0][63:0] counter_val_i,
  output logic [NumCounters-1:0]      counter_inc_o,
  output logic [NumCounters-1:0]      counter_we_o,
  output logic [NumCounters-1:0]      counterh_we_o,
  output logic [31:0]                 counter_wdata_o
);

  cnt_port_state_e state_q, state_d;
  cnt_req_t        req_d, req_q;
  logic            strobe_pend_q;
  logic [31:0]     rdata_d, rdata_q;
  logic            err_q;
  logic            accept;
  logic            in_range;
  logic [63:0]     sel_val;
  logic            snap_hit;
  logic [31:0]     snap_data;

  assign req_ready_o = (state_q == CntIdle);
  assign accept      = req_i && req_ready_o;
  assign in_range    = (32'(req_idx_i) < NumCounters);
  assign req_d       = '{we: req_we_i, hi: req_hi_i, idx: MaxIdxW'(req_idx_i), wdata: req_wdata_i};

  // Index decode by comparison keeps out-of-range indices from reading past
  // the counter bank.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned (which would infer a latch).
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (req_idx_i == IdxW'(i)) sel_val = counter_val_i[i];
    end
  end

`ifdef IBEX_COUNTER_SNAPSHOT_EN
  ibex_counter_snapshot u_snapshot (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .accept_i   (accept),
    .we_i       (req_we_i),
    .hi_i       (req_hi_i),
    .in_range_i (in_range),
    .idx_i      (req_d.idx),
    .live_hi_i  (sel_val[63:32]),
    .hit_o      (snap_hit),
    .snap_o     (snap_data)
  );
`else
  assign snap_hit  = 1'b0;
  assign snap_data = '0;
`endif

  always_comb begin
    rdata_d = '0;
    if (!req_we_i && in_range) begin
      if (!req_hi_i)     rdata_d = sel_val[31:0];
      else if (snap_hit) rdata_d = snap_data;
      else               rdata_d = sel_val[63:32];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CntIdle: if (req_i)       state_d = CntResp;
      CntResp: if (rsp_ready_i) state_d = CntIdle;
      default:                  state_d = CntIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= CntIdle;
      req_q         <= '0;
      strobe_pend_q <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      strobe_pend_q <= accept;
      if (accept) begin
        req_q   <= req_d;
        rdata_q <= rdata_d;
        err_q   <= !in_range;
      end
    end
  end

  assign rsp_valid_o     = (state_q == CntResp);
  assign rsp_rdata_o     = rdata_q;
  assign rsp_err_o       = err_q;
  assign counter_wdata_o = req_q.wdata;

  // Strobes fire only in the first cycle after accept; err_q suppresses them
  // for indices with no counter behind them.
  always_comb begin
    counter_we_o  = '0;
    counterh_we_o = '0;
    if (strobe_pend_q && req_q.we && !err_q) begin
      for (int i = 0; i < NumCounters; i++) begin
        if (req_q.idx == MaxIdxW'(i)) begin
          if (req_q.hi) counterh_we_o[i] = 1'b1;
          else          counter_we_o[i]  = 1'b1;
        end
      end
    end
  end

  // A counter being written this cycle must not also increment.
  assign counter_inc_o = event_i & ~inhibit_i & ~(counter_we_o | counterh_we_o);

endmodule

// File: tb/tb_ibex_counter_csr_port.sv
// tb_ibex_counter_csr_port
//  Self-checking bench for ibex_counter_csr_port (NumCounters=3). The bench
//  plays the role of the counter bank: it owns the 64-bit counter values,
//  applies writes when they are issued, and predicts read data, including the
//  lo/hi snapshot behaviour when IBEX_COUNTER_SNAPSHOT_EN is defined.
module tb_ibex_counter_csr_port;

  localparam int N = 3;
`ifdef IBEX_COUNTER_SNAPSHOT_EN
  localparam bit SnapEn = 1'b1;
`else
  localparam bit SnapEn = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_i = 1'b0;
  logic              req_ready_o;
  logic              req_we_i = 1'b0;
  logic              req_hi_i = 1'b0;
  logic [1:0]        req_idx_i = '0;
  logic [31:0]       req_wdata_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic [N-1:0]      event_i = '0;
  logic [N-1:0]      inhibit_i = '0;
  logic [N-1:0][63:0] counter_val_i = '0;
  logic [N-1:0]      counter_inc_o;
  logic [N-1:0]      counter_we_o;
  logic [N-1:0]      counterh_we_o;
  logic [31:0]       counter_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference snapshot state: what a coherent lo-then-hi read should return.
  bit          snap_valid = 1'b0;
  int          snap_tag   = 0;
  logic [31:0] snap_val   = '0;

  ibex_counter_csr_port #(.NumCounters(N)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .req_ready_o     (req_ready_o),
    .req_we_i        (req_we_i),
    .req_hi_i        (req_hi_i),
    .req_idx_i       (req_idx_i),
    .req_wdata_i     (req_wdata_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .event_i         (event_i),
    .inhibit_i       (inhibit_i),
    .counter_val_i   (counter_val_i),
    .counter_inc_o   (counter_inc_o),
    .counter_we_o    (counter_we_o),
    .counterh_we_o   (counterh_we_o),
    .counter_wdata_o (counter_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 1);
    check({tag, "_rsp_valid"}, rsp_valid_o, 0);
    check({tag, "_rdata"}, rsp_rdata_o, 0);
    check({tag, "_err"}, rsp_err_o, 0);
    check({tag, "_strobes"}, {counterh_we_o, counter_we_o}, 0);
    check({tag, "_wdata"}, counter_wdata_o, 0);
  endtask

  // One complete transaction: issue, check the T+1 response and strobes,
  // hold the response for 'hold' cycles, then consume it.
  task automatic do_req(input bit we, input bit hi, input int idx, input logic [31:0] wdata,
                        input int hold, input logic [N-1:0] ev, input logic [N-1:0] inh);
    bit           err;
    logic [31:0]  exp_rd;
    logic [N-1:0] exp_stb;
    logic [63:0]  cur;
    @(negedge clk_i);
    event_i   = ev;
    inhibit_i = inh;
    check("req_ready_before", req_ready_o, 1);
    err     = (idx >= N);
    cur     = err ? 64'h0 : counter_val_i[idx];
    exp_rd  = 32'h0;
    exp_stb = '0;
    if (we && !err) exp_stb[idx] = 1'b1;
    if (!we && !err) begin
      if (!hi)                                      exp_rd = cur[31:0];
      else if (SnapEn && snap_valid && snap_tag == idx) exp_rd = snap_val;
      else                                          exp_rd = cur[63:32];
    end
    if (SnapEn) begin
      if (we) begin
        if (snap_valid && snap_tag == idx) snap_valid = 1'b0;
      end else if (!hi) begin
        snap_valid = !err;
        snap_tag   = idx;
        snap_val   = cur[63:32];
      end else if (snap_valid && snap_tag == idx) begin
        snap_valid = 1'b0;
      end
    end
    req_i       = 1'b1;
    req_we_i    = we;
    req_hi_i    = hi;
    req_idx_i   = 2'(idx);
    req_wdata_i = wdata;
    @(negedge clk_i);
    req_i       = 1'b0;
    req_wdata_i = $urandom;
    check("rsp_valid_t1", rsp_valid_o, 1);
    check("req_ready_t1", req_ready_o, 0);
    check("rdata_t1", rsp_rdata_o, exp_rd);
    check("err_t1", rsp_err_o, err);
    check("we_lo_t1", counter_we_o, hi ? '0 : exp_stb);
    check("we_hi_t1", counterh_we_o, hi ? exp_stb : '0);
    check("inc_t1", counter_inc_o, ev & ~inh & ~exp_stb);
    if (we && !err) begin
      check("wdata_t1", counter_wdata_o, wdata);
      // The counter body takes the write at the end of this cycle.
      if (hi) counter_val_i[idx][63:32] = wdata;
      else    counter_val_i[idx][31:0]  = wdata;
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk_i);
      check("rsp_valid_hold", rsp_valid_o, 1);
      check("rdata_hold", rsp_rdata_o, exp_rd);
      check("req_ready_hold", req_ready_o, 0);
      check("strobes_hold", {counterh_we_o, counter_we_o}, 0);
      check("inc_hold", counter_inc_o, ev & ~inh);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_valid_done", rsp_valid_o, 0);
    check("req_ready_done", req_ready_o, 1);
  endtask

  initial begin
    logic [N-1:0] ev, inh;

    // Reset and idle behaviour.
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      ev = N'($urandom); inh = N'($urandom);
      event_i = ev; inhibit_i = inh;
      #1;
      check_reset_outputs("idle");
      check("idle_inc", counter_inc_o, ev & ~inh);
    end

    // Write lo idx1, strobe blocks its increment, then read it back.
    counter_val_i[1] = 64'h0000_0007_0000_0010;
    do_req(1'b1, 1'b0, 1, 32'hDEAD_BEEF, 0, 3'b111, 3'b000);
    do_req(1'b0, 1'b0, 1, 32'h0, 0, 3'b111, 3'b000);
    check("raw_value", counter_val_i[1][31:0], 32'hDEAD_BEEF);

    // Hi read of idx0 with the response held off for three cycles.
    counter_val_i[0] = 64'h0000_0005_FFFF_FFFF;
    do_req(1'b0, 1'b1, 0, 32'h0, 3, 3'b011, 3'b001);

    // Out-of-range index, read and write.
    do_req(1'b0, 1'b0, 3, 32'h0, 1, 3'b111, 3'b000);
    do_req(1'b1, 1'b1, 3, 32'h1234_5678, 0, 3'b111, 3'b000);

    // Lo read, counter carries into the upper half, then hi read.
    counter_val_i[2] = 64'h0000_0001_FFFF_FFFF;
    do_req(1'b0, 1'b0, 2, 32'h0, 0, 3'b000, 3'b000);
    counter_val_i[2] = 64'h0000_0002_0000_0000;
    do_req(1'b0, 1'b1, 2, 32'h0, 0, 3'b000, 3'b000);

    // Randomized mix of reads and writes with counters advancing between them.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) counter_val_i[i] = {$urandom, $urandom};
        else counter_val_i[i] = counter_val_i[i] + 64'($urandom_range(0, 3));
      end
      do_req(bit'($urandom_range(0, 3) == 0), bit'($urandom), $urandom_range(0, 3),
             $urandom, $urandom_range(0, 2), N'($urandom), N'($urandom));
    end

    // Reset during a pending response discards it and the snapshot.
    counter_val_i[2] = 64'h0000_00AA_0000_0001;
    do_req(1'b0, 1'b0, 0, 32'h0, 0, 3'b000, 3'b000);
    @(negedge clk_i);
    req_i = 1'b1; req_we_i = 1'b0; req_hi_i = 1'b0; req_idx_i = 2'd2;
    @(negedge clk_i);
    req_i = 1'b0;
    check("mid_rsp_valid", rsp_valid_o, 1);
    check("mid_rdata", rsp_rdata_o, 32'h0000_0001);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    snap_valid = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    counter_val_i[2] = 64'h0000_00BB_0000_0002;
    do_req(1'b0, 1'b1, 2, 32'h0, 0, 3'b000, 3'b000);
    check("post_reset_live", snap_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
